// File: rtl/cpu_pkg.sv
// Shared datapath widths and index/data types for the pipelined 64-bit ARM core.
// Pure declarations: no logic, no latency, no flow control.
// Imported by every operand-stage file.
package cpu_pkg;
    localparam int DATA_W   = 64;
    localparam int REG_W    = 5;
    localparam int ZERO_REG = 31;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the ID/EX stage and its neighbours (decode, regfile, EX/MEM, MEM/WB).
// Wires only; the stage itself adds one register cycle ID->EX.
// id_stall is the only backpressure signal and flows back toward IF/ID.
interface id_ex_operand_stage_if;
    import cpu_pkg::*;

    logic     id_valid;
    reg_idx_t id_rn;
    reg_idx_t id_rm;
    logic     id_uses_rn;
    logic     id_uses_rm;
    reg_idx_t id_rd;
    logic     id_reg_write;
    logic     id_mem_read;
    data_t    rf_read_data1;
    data_t    rf_read_data2;
    logic     mem_reg_write;
    reg_idx_t mem_rd;
    data_t    mem_result;
    logic     wb_reg_write;
    reg_idx_t wb_rd;
    data_t    wb_data;
    logic     ex_hold;
    logic     ex_flush;
    logic     id_stall;
    logic     ex_valid;
    reg_idx_t ex_rd;
    logic     ex_reg_write;
    logic     ex_mem_read;
    data_t    ex_op_a;
    data_t    ex_op_b;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
               id_mem_read, rf_read_data1, rf_read_data2, mem_reg_write, mem_rd,
               mem_result, wb_reg_write, wb_rd, wb_data, ex_hold, ex_flush,
        input  id_stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_op_a, ex_op_b
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
               id_mem_read, rf_read_data1, rf_read_data2, mem_reg_write, mem_rd,
               mem_result, wb_reg_write, wb_rd, wb_data, ex_hold, ex_flush,
        output id_stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_op_a, ex_op_b
    );
endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: XZR -> 0, then EX/MEM, then MEM/WB, then the stored value.
// Purely combinational, zero cycles.
// No flow control.
module fwd_mux
    import cpu_pkg::*;
(
    input  reg_idx_t src,
    input  data_t    stored,
    input  logic     mem_en,
    input  reg_idx_t mem_rd,
    input  data_t    mem_val,
    input  logic     wb_en,
    input  reg_idx_t wb_rd,
    input  data_t    wb_val,
    output data_t    fwd_val
);
    always_comb begin
        fwd_val = stored;
        // EX/MEM is checked first because it holds the younger result.
        if (src == XZR)
            fwd_val = '0;
        else if (mem_en && mem_rd == src && mem_rd != XZR)
            fwd_val = mem_val;
        else if (wb_en && wb_rd == src && wb_rd != XZR)
            fwd_val = wb_val;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: captures decoded fields and bypassed regfile data, forwards at the EX side.
// Latency: 1 cycle ID->EX; forwarding is combinational.
// Backpressure: id_stall on load-use or ex_hold; load-use inserts a single bubble.
module id_ex_operand_stage
    import cpu_pkg::*;
(
    input logic             clk,
    input logic             reset,
    id_ex_operand_stage_if.slave bus
);
    logic     ex_valid_q;
    reg_idx_t ex_rd_q;
    logic     ex_reg_write_q;
    logic     ex_mem_read_q;
    reg_idx_t ex_rn_q;
    reg_idx_t ex_rm_q;
    data_t    op_a_q;
    data_t    op_b_q;
    data_t    cap_a;
    data_t    cap_b;
    logic     load_use;

    // The regfile writes on the same edge we capture, so its read data is stale
    // for a matching WB write; only the WB tuple can apply here.
    fwd_mux u_cap_a (
        .src(bus.id_rn), .stored(bus.rf_read_data1),
        .mem_en(1'b0), .mem_rd('0), .mem_val('0),
        .wb_en(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_val(bus.wb_data),
        .fwd_val(cap_a)
    );

    fwd_mux u_cap_b (
        .src(bus.id_rm), .stored(bus.rf_read_data2),
        .mem_en(1'b0), .mem_rd('0), .mem_val('0),
        .wb_en(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_val(bus.wb_data),
        .fwd_val(cap_b)
    );

    always_comb begin
        load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != XZR) && bus.id_valid &&
                   ((bus.id_uses_rn && bus.id_rn == ex_rd_q) ||
                    (bus.id_uses_rm && bus.id_rm == ex_rd_q));
    end

    assign bus.id_stall = load_use || bus.ex_hold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= XZR;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rn_q        <= '0;
            ex_rm_q        <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
        end else if (bus.ex_hold) begin
            ex_valid_q <= ex_valid_q;
        end else if (bus.ex_flush || load_use) begin
            // Remaining fields go stale but are masked by ex_valid.
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q     <= bus.id_valid;
            ex_rd_q        <= bus.id_rd;
            ex_reg_write_q <= bus.id_reg_write;
            ex_mem_read_q  <= bus.id_mem_read;
            ex_rn_q        <= bus.id_rn;
            ex_rm_q        <= bus.id_rm;
            op_a_q         <= cap_a;
            op_b_q         <= cap_b;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_reg_write = ex_reg_write_q && ex_valid_q;
    assign bus.ex_mem_read  = ex_mem_read_q && ex_valid_q;

    fwd_mux u_fwd_a (
        .src(ex_rn_q), .stored(op_a_q),
        .mem_en(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_val(bus.mem_result),
        .wb_en(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_val(bus.wb_data),
        .fwd_val(bus.ex_op_a)
    );

    fwd_mux u_fwd_b (
        .src(ex_rm_q), .stored(op_b_q),
        .mem_en(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_val(bus.mem_result),
        .wb_en(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_val(bus.wb_data),
        .fwd_val(bus.ex_op_b)
    );
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage with hand-computed expectations.
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid      = 1'b0;
        bus.id_rn         = '0;
        bus.id_rm         = '0;
        bus.id_uses_rn    = 1'b0;
        bus.id_uses_rm    = 1'b0;
        bus.id_rd         = '0;
        bus.id_reg_write  = 1'b0;
        bus.id_mem_read   = 1'b0;
        bus.rf_read_data1 = '0;
        bus.rf_read_data2 = '0;
        bus.mem_reg_write = 1'b0;
        bus.mem_rd        = '0;
        bus.mem_result    = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_data       = '0;
        bus.ex_hold       = 1'b0;
        bus.ex_flush      = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        bus.id_valid = 1'b1;
        bus.id_rn = 5'd5; bus.id_uses_rn = 1'b1; bus.id_reg_write = 1'b1;
        bus.rf_read_data1 = 64'h1234;
        step();
        step();
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_ex_reg_write", 64'(bus.ex_reg_write), 64'd0);
        chk("rst_ex_mem_read", 64'(bus.ex_mem_read), 64'd0);
        chk("rst_ex_rd", 64'(bus.ex_rd), 64'd31);
        chk("rst_op_a", bus.ex_op_a, 64'd0);
        chk("rst_op_b", bus.ex_op_b, 64'd0);
        chk("rst_id_stall", 64'(bus.id_stall), 64'd0);

        // WB capture bypass on rn, rm read straight from the regfile
        reset = 1'b1;
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rn = 5'd5; bus.id_rm = 5'd6;
        bus.id_uses_rn = 1'b1; bus.id_uses_rm = 1'b1;
        bus.id_rd = 5'd9; bus.id_reg_write = 1'b1;
        bus.rf_read_data1 = 64'h11; bus.rf_read_data2 = 64'h22;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'hAA;
        step();
        bus.id_rn = 5'd31; bus.wb_rd = 5'd31; bus.wb_data = 64'hBB;
        bus.rf_read_data1 = 64'h33;
        #1;
        chk("byp_op_a", bus.ex_op_a, 64'hAA);
        chk("byp_op_b", bus.ex_op_b, 64'h22);
        chk("byp_ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("byp_ex_rd", 64'(bus.ex_rd), 64'd9);
        chk("byp_ex_reg_write", 64'(bus.ex_reg_write), 64'd1);
        step();
        chk("byp_xzr_op_a", bus.ex_op_a, 64'd0);
        chk("byp_xzr_op_b", bus.ex_op_b, 64'h22);

        // Forward priority EX/MEM over MEM/WB over stored
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rn = 5'd3; bus.id_uses_rn = 1'b1;
        bus.id_rd = 5'd10; bus.id_reg_write = 1'b1; bus.rf_read_data1 = 64'h55;
        step();
        bus.id_valid = 1'b0;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd3; bus.mem_result = 64'h100;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'h200;
        #1;
        chk("fwd_mem_wins", bus.ex_op_a, 64'h100);
        bus.mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", bus.ex_op_a, 64'h200);
        bus.wb_reg_write = 1'b0;
        #1;
        chk("fwd_none", bus.ex_op_a, 64'h55);

        // Load-use: one bubble, then the consumer enters EX
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_reg_write = 1'b1;
        bus.id_rd = 5'd7; bus.id_rn = 5'd1; bus.id_uses_rn = 1'b1;
        step();
        bus.id_mem_read = 1'b0; bus.id_uses_rn = 1'b0; bus.id_uses_rm = 1'b1;
        bus.id_rm = 5'd7; bus.id_rn = 5'd2; bus.id_rd = 5'd12;
        bus.rf_read_data2 = 64'h77;
        #1;
        chk("lu_stall", 64'(bus.id_stall), 64'd1);
        chk("lu_ex_mem_read", 64'(bus.ex_mem_read), 64'd1);
        step();
        chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("lu_bubble_mem_read", 64'(bus.ex_mem_read), 64'd0);
        chk("lu_bubble_stall", 64'(bus.id_stall), 64'd0);
        step();
        chk("lu_enter_valid", 64'(bus.ex_valid), 64'd1);
        chk("lu_enter_rd", 64'(bus.ex_rd), 64'd12);
        chk("lu_enter_op_b", bus.ex_op_b, 64'h77);
        chk("lu_enter_stall", 64'(bus.id_stall), 64'd0);

        // A load to XZR never causes a stall
        bus.id_mem_read = 1'b1; bus.id_rd = 5'd31;
        step();
        bus.id_mem_read = 1'b0; bus.id_rm = 5'd31;
        bus.id_rn = 5'd4; bus.rf_read_data1 = 64'h44; bus.id_rd = 5'd13;
        #1;
        chk("xzr_load_present", 64'(bus.ex_mem_read), 64'd1);
        chk("xzr_no_stall", 64'(bus.id_stall), 64'd0);

        // Hold beats flush; then flush alone squashes
        step();
        bus.ex_hold = 1'b1; bus.ex_flush = 1'b1;
        bus.id_rd = 5'd14; bus.rf_read_data1 = 64'h99;
        #1;
        chk("hold_stall", 64'(bus.id_stall), 64'd1);
        step();
        chk("hold_valid", 64'(bus.ex_valid), 64'd1);
        chk("hold_rd", 64'(bus.ex_rd), 64'd13);
        chk("hold_op_a", bus.ex_op_a, 64'h44);
        bus.ex_hold = 1'b0;
        step();
        chk("flush_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush_reg_write", 64'(bus.ex_reg_write), 64'd0);
        bus.ex_flush = 1'b0;

        // ALU chain X1=X2+X3 then X4=X1+X1
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rn = 5'd2; bus.id_rm = 5'd3;
        bus.id_uses_rn = 1'b1; bus.id_uses_rm = 1'b1;
        bus.id_rd = 5'd1; bus.id_reg_write = 1'b1;
        bus.rf_read_data1 = 64'd2; bus.rf_read_data2 = 64'd3;
        step();
        bus.id_rn = 5'd1; bus.id_rm = 5'd1; bus.id_rd = 5'd4;
        bus.rf_read_data1 = 64'hDEAD; bus.rf_read_data2 = 64'hDEAD;
        #1;
        chk("chain_stall1", 64'(bus.id_stall), 64'd0);
        step();
        bus.id_valid = 1'b0;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd1; bus.mem_result = 64'd5;
        #1;
        chk("chain_op_a", bus.ex_op_a, 64'd5);
        chk("chain_op_b", bus.ex_op_b, 64'd5);
        chk("chain_stall2", 64'(bus.id_stall), 64'd0);
        chk("chain_rd", 64'(bus.ex_rd), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
